// File: rtl/scan_mux_if.sv
// scan_mux_if: channel data, select/mode/enable controls and registered mux outputs
//   master: data, mux_select, mode, enable (+chan_mask with SCAN_MASK_EN) out; out, out_valid, cur_chan, wrap in
//   slave : the mirror image, used by scan_mux
interface scan_mux_if #(parameter int NUM_CH = 7, parameter int WIDTH = 1, parameter int SEL_W = 3);
  logic [NUM_CH*WIDTH-1:0] data;
  logic [SEL_W-1:0]        mux_select;
  logic                    mode;
  logic                    enable;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic [SEL_W-1:0]        cur_chan;
  logic                    wrap;
`ifdef SCAN_MASK_EN
  logic [NUM_CH-1:0]       chan_mask;
  modport master (output data, mux_select, mode, enable, chan_mask, input out, out_valid, cur_chan, wrap);
  modport slave  (input data, mux_select, mode, enable, chan_mask, output out, out_valid, cur_chan, wrap);
`else
  modport master (output data, mux_select, mode, enable, input out, out_valid, cur_chan, wrap);
  modport slave  (input data, mux_select, mode, enable, output out, out_valid, cur_chan, wrap);
`endif
endinterface

// File: rtl/scan_mux.sv
// scan_mux: registered NUM_CH x WIDTH mux, manual select or self-stepping scan holding each channel DWELL cycles
//   clk, rst_n (async, active low); bus: scan_mux_if.slave
//   SCAN_MASK_EN: adds bus.chan_mask; scan skips masked channels, masked channels give out=0/out_valid=0
module scan_mux #(
  parameter int NUM_CH = 7,
  parameter int WIDTH  = 1,
  parameter int SEL_W  = 3,
  parameter int DWELL  = 4
) (
  input logic          clk,
  input logic          rst_n,
  scan_mux_if.slave    bus
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  logic [CW-1:0]     cnt, cnt_n;
  logic [SEL_W-1:0]  cur, nxt, hi, lo, adv;
  logic              in_rng, have_hi, m_cur, adv_wrap, wrap_n, v_n;
  logic [WIDTH-1:0]  d_n;
  logic [NUM_CH-1:0] m;
`ifdef SCAN_MASK_EN
  assign m = bus.chan_mask;
`else
  assign m = '1;
`endif
  assign in_rng   = int'(cur) < NUM_CH;
  assign adv      = have_hi ? hi : lo;
  assign adv_wrap = in_rng && !have_hi;
  assign bus.cur_chan = cur;
  // Downward sweep: lo ends as the lowest enabled channel, hi as the lowest enabled channel above cur.
  // No enabled channel above cur means the advance wraps to lo.
  always_comb begin
    have_hi = 1'b0;
    hi = '0;
    lo = cur;
    m_cur = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cur == SEL_W'(i)) m_cur = m[i];
      if (m[i]) begin
        lo = SEL_W'(i);
        if (in_rng && i > int'(cur)) begin
          hi = SEL_W'(i);
          have_hi = 1'b1;
        end
      end
    end
  end
  // Out-of-range or masked current channel leaves immediately; otherwise hold for DWELL enabled edges.
  always_comb begin
    nxt = cur;
    cnt_n = cnt;
    wrap_n = 1'b0;
    if (!bus.mode) begin
      nxt = bus.mux_select;
      cnt_n = '0;
    end else if (m == '0) begin
      cnt_n = '0;
    end else if (!in_rng || !m_cur || cnt == LAST) begin
      nxt = adv;
      cnt_n = '0;
      wrap_n = adv_wrap;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end
  always_comb begin
    d_n = '0;
    v_n = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (nxt == SEL_W'(i) && m[i]) begin
        d_n = bus.data[i*WIDTH +: WIDTH];
        v_n = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur <= '0;
      cnt <= '0;
      bus.out <= '0;
      bus.out_valid <= 1'b0;
      bus.wrap <= 1'b0;
    end else if (bus.enable) begin
      cur <= nxt;
      cnt <= cnt_n;
      bus.out <= d_n;
      bus.out_valid <= v_n;
      bus.wrap <= wrap_n;
    end else begin
      bus.out_valid <= 1'b0;
      bus.wrap <= 1'b0;
    end
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: checks scan_mux (7ch x 3b DWELL=4, and 7ch x 1b DWELL=1) against a queue-based reference model
module tb_scan_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  scan_mux_if #(.NUM_CH(7), .WIDTH(3), .SEL_W(3)) ia();
  scan_mux_if #(.NUM_CH(7), .WIDTH(1), .SEL_W(3)) ib();
  scan_mux #(.NUM_CH(7), .WIDTH(3), .SEL_W(3), .DWELL(4)) ua (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  scan_mux #(.NUM_CH(7), .WIDTH(1), .SEL_W(3), .DWELL(1)) ub (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  typedef struct {int cur; int cnt; int out; bit valid; bit wrap;} st_t;
  typedef struct {int sel; int out; bit valid;} vec_t;
  st_t ma, mb;
  bit [6:0] mask_a = '1, mask_b = '1;
  int n_chk = 0, n_fail = 0;
  vec_t vecs[8];
  // Reference: list the enabled channels, step to the first enabled one above the current index, else wrap to the lowest.
  function automatic st_t step(st_t s, logic [20:0] d, int w, int sel, bit mode, bit en, bit [6:0] m, int dwell);
    st_t r = s;
    int on[$];
    int up[$];
    r.wrap = 1'b0;
    if (!en) begin
      r.valid = 1'b0;
      return r;
    end
    for (int i = 0; i < 7; i++) if (m[i]) on.push_back(i);
    if (!mode) begin
      r.cur = sel;
      r.cnt = 0;
    end else if (on.size() == 0) begin
      r.cnt = 0;
    end else if (s.cur >= 7) begin
      r.cur = on[0];
      r.cnt = 0;
    end else if (!m[s.cur[2:0]] || s.cnt == dwell - 1) begin
      up = on.find_first with (item > s.cur);
      r.cur = up.size() > 0 ? up[0] : on[0];
      r.wrap = r.cur <= s.cur;
      r.cnt = 0;
    end else begin
      r.cnt = s.cnt + 1;
    end
    r.valid = r.cur < 7 ? m[r.cur[2:0]] : 1'b0;
    r.out = r.valid ? int'((d >> (r.cur * w)) & ((21'd1 << w) - 21'd1)) : 0;
    return r;
  endfunction
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cmp_all();
    chk("a_out", int'(ia.out), ma.out);
    chk("a_valid", int'(ia.out_valid), int'(ma.valid));
    chk("a_cur", int'(ia.cur_chan), ma.cur);
    chk("a_wrap", int'(ia.wrap), int'(ma.wrap));
    chk("b_out", int'(ib.out), mb.out);
    chk("b_valid", int'(ib.out_valid), int'(mb.valid));
    chk("b_cur", int'(ib.cur_chan), mb.cur);
    chk("b_wrap", int'(ib.wrap), int'(mb.wrap));
  endtask
  task automatic drive_masks();
`ifdef SCAN_MASK_EN
    ia.chan_mask = mask_a;
    ib.chan_mask = mask_b;
`endif
  endtask
  task automatic cycle();
    @(posedge clk);
    ma = step(ma, 21'(ia.data), 3, int'(ia.mux_select), ia.mode, ia.enable, mask_a, 4);
    mb = step(mb, 21'(ib.data), 1, int'(ib.mux_select), ib.mode, ib.enable, mask_b, 1);
    #1;
    cmp_all();
  endtask
  initial begin
    int exp_c;
    vecs = '{'{0, 0, 1}, '{1, 1, 1}, '{2, 1, 1}, '{3, 0, 1}, '{4, 1, 1}, '{5, 0, 1}, '{6, 1, 1}, '{7, 0, 0}};
    ma = '{default: 0};
    mb = '{default: 0};
    ia.data = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    ia.mode = 1'b1;
    ia.enable = 1'b1;
    ia.mux_select = '0;
    ib.data = 7'b1010110;
    ib.mode = 1'b0;
    ib.enable = 1'b1;
    ib.mux_select = '0;
    drive_masks();
    #3;
    chk("rst_a_out", int'(ia.out), 0);
    chk("rst_a_valid", int'(ia.out_valid), 0);
    chk("rst_a_cur", int'(ia.cur_chan), 0);
    chk("rst_b_wrap", int'(ib.wrap), 0);
    #9 rst_n = 1'b1;
    // Manual table on b alongside a free-running scan on a
    for (int e = 1; e <= 56; e++) begin
      if (e <= 8) ib.mux_select = 3'(vecs[e-1].sel);
      cycle();
      exp_c = (e / 4) % 7;
      chk("t3_cur", int'(ia.cur_chan), exp_c);
      chk("t3_out", int'(ia.out), exp_c);
      chk("t3_wrap", int'(ia.wrap), int'(e % 28 == 0));
      if (e <= 8) begin
        chk("t2_out", int'(ib.out), vecs[e-1].out);
        chk("t2_valid", int'(ib.out_valid), int'(vecs[e-1].valid));
      end
    end
    // Freeze at ch2 with count 1, then resume
    for (int e = 0; e < 9; e++) cycle();
    ia.enable = 1'b0;
    for (int e = 0; e < 3; e++) begin
      cycle();
      chk("t4_hold_cur", int'(ia.cur_chan), 2);
      chk("t4_hold_out", int'(ia.out), 2);
      chk("t4_hold_valid", int'(ia.out_valid), 0);
    end
    ia.enable = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      cycle();
      chk("t4_resume_cur", int'(ia.cur_chan), e < 3 ? 2 : 3);
      chk("t4_resume_valid", int'(ia.out_valid), 1);
    end
    // Manual 5 then scan from 5 with a full dwell
    ia.mode = 1'b0;
    ia.mux_select = 3'd5;
    for (int e = 0; e < 2; e++) begin
      cycle();
      chk("t5_man_cur", int'(ia.cur_chan), 5);
    end
    ia.mode = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      chk("t5_cur", int'(ia.cur_chan), e < 4 ? 5 : (e < 8 ? 6 : 0));
      chk("t5_wrap", int'(ia.wrap), int'(e == 8));
    end
    // Async reset between edges
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("t1_out", int'(ia.out), 0);
    chk("t1_valid", int'(ia.out_valid), 0);
    chk("t1_cur", int'(ia.cur_chan), 0);
    chk("t1_wrap", int'(ia.wrap), 0);
    chk("t1_b_cur", int'(ib.cur_chan), 0);
    ma = '{default: 0};
    mb = '{default: 0};
    #2 rst_n = 1'b1;
    // Out-of-range select, then scan entry goes straight to 0, then DWELL=1 stepping
    ib.mode = 1'b0;
    ib.mux_select = 3'd7;
    cycle();
    chk("oor_cur", int'(ib.cur_chan), 7);
    chk("oor_valid", int'(ib.out_valid), 0);
    ib.mode = 1'b1;
    cycle();
    chk("oor_scan_cur", int'(ib.cur_chan), 0);
    chk("oor_scan_wrap", int'(ib.wrap), 0);
    for (int e = 1; e <= 7; e++) begin
      cycle();
      chk("d1_cur", int'(ib.cur_chan), e % 7);
      chk("d1_wrap", int'(ib.wrap), int'(e == 7));
    end
    for (int e = 0; e < 3000; e++) begin
      ia.data = 21'($urandom);
      ib.data = 7'($urandom);
      ia.mux_select = 3'($urandom_range(0, 7));
      ib.mux_select = 3'($urandom_range(0, 7));
      ia.enable = $urandom_range(0, 4) != 0;
      ib.enable = $urandom_range(0, 4) != 0;
      if ($urandom_range(0, 15) == 0) ia.mode = ~ia.mode;
      if ($urandom_range(0, 7) == 0) ib.mode = ~ib.mode;
`ifdef SCAN_MASK_EN
      if ($urandom_range(0, 31) == 0) mask_a = 7'($urandom);
      if ($urandom_range(0, 31) == 0) mask_b = $urandom_range(0, 3) == 0 ? 7'd0 : 7'($urandom);
      drive_masks();
`endif
      cycle();
    end
`ifdef SCAN_MASK_EN
    begin
      int seq[6] = '{2, 5, 0, 2, 5, 0};
      mask_b = 7'b0100101;
      drive_masks();
      ib.enable = 1'b1;
      ib.mode = 1'b0;
      ib.mux_select = 3'd0;
      cycle();
      ib.mode = 1'b1;
      for (int e = 0; e < 6; e++) begin
        cycle();
        chk("t6_cur", int'(ib.cur_chan), seq[e]);
        chk("t6_wrap", int'(ib.wrap), int'(seq[e] == 0));
      end
      mask_b = '0;
      drive_masks();
      for (int e = 0; e < 3; e++) begin
        cycle();
        chk("t6_zero_cur", int'(ib.cur_chan), 0);
        chk("t6_zero_valid", int'(ib.out_valid), 0);
        chk("t6_zero_out", int'(ib.out), 0);
      end
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
